// File: rtl/p3_reg_file_pkg.sv
// Shared types and sizing constants for the Simple RISC Machine register file.
package p3_pkg;

  localparam int DATA_W     = 16;
  localparam int REG_ADDR_W = 3;

  typedef logic [15:0] word_t;
  typedef logic [2:0]  regnum_t;

endpackage

// File: rtl/p3_reg_file_if.sv
// Controller-to-register-file bus: write port, read index and read data.
interface p3_reg_file_if #(
  parameter int DATA_W = p3_pkg::DATA_W,
  parameter int ADDR_W = p3_pkg::REG_ADDR_W
);

  logic [DATA_W-1:0] data_in;
  logic [ADDR_W-1:0] writenum;
  logic              write;
  logic [ADDR_W-1:0] readnum;
  logic [DATA_W-1:0] data_out;

  modport master (
    output data_in,
    output writenum,
    output write,
    output readnum,
    input  data_out
  );

  modport slave (
    input  data_in,
    input  writenum,
    input  write,
    input  readnum,
    output data_out
  );

endinterface

// File: rtl/p3_reg_file_dec.sv
// Binary-to-one-hot decoder, N inputs to 2**N outputs.
module p3_decoder #(
  parameter int N = p3_pkg::REG_ADDR_W
) (
  input  logic [N-1:0]        i_bin,
  output logic [(1<<N)-1:0]   o_onehot
);

  always_comb begin
    o_onehot        = '0;
    o_onehot[i_bin] = 1'b1;
  end

endmodule

// File: rtl/p3_reg_file_load_en.sv
// DATA_W-bit register with synchronous clear and load enable; clear wins over load.
module p3_reg_load_en #(
  parameter int DATA_W = p3_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_load,
  input  logic [DATA_W-1:0] i_d,
  output logic [DATA_W-1:0] o_q
);

  logic [DATA_W-1:0] r_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_q <= '0;
    end else if (i_load) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/p3_reg_file.sv
// Eight-entry register file: one synchronous write port, one combinational read port.
module p3_reg_file #(
  parameter int DATA_W = p3_pkg::DATA_W,
  parameter int NREGS  = (1 << p3_pkg::REG_ADDR_W)
) (
  input  logic          clk,
  input  logic          reset,
  p3_reg_file_if.slave  bus
);

  localparam int ADDR_W = $clog2(NREGS);

  logic [NREGS-1:0]  w_wr_dec;
  logic [NREGS-1:0]  w_ld_en;
  logic [NREGS-1:0]  w_rd_sel;
  logic [DATA_W-1:0] w_q [NREGS];
  logic [DATA_W-1:0] w_rd_data;

  p3_decoder #(.N(ADDR_W)) u_wr_dec (
    .i_bin    (bus.writenum),
    .o_onehot (w_wr_dec)
  );

  assign w_ld_en = w_wr_dec & {NREGS{bus.write}};

  generate
    for (genvar gi = 0; gi < NREGS; gi++) begin : g_regs
      p3_reg_load_en #(.DATA_W(DATA_W)) u_reg (
        .clk    (clk),
        .reset  (reset),
        .i_load (w_ld_en[gi]),
        .i_d    (bus.data_in),
        .o_q    (w_q[gi])
      );
    end
  endgenerate

  // Read side is an AND-OR mux driven by a one-hot select, no clock involved.
  p3_decoder #(.N(ADDR_W)) u_rd_dec (
    .i_bin    (bus.readnum),
    .o_onehot (w_rd_sel)
  );

  always_comb begin
    w_rd_data = '0;
    for (int i = 0; i < NREGS; i++) begin
      w_rd_data = w_rd_data | (w_q[i] & {DATA_W{w_rd_sel[i]}});
    end
  end

  assign bus.data_out = w_rd_data;

endmodule

// File: tb/tb_p3_reg_file.sv
// Self-checking bench for p3_reg_file: vector table plus hand-written corner sequences.
module tb_p3_reg_file;
  import p3_pkg::*;

  typedef struct {
    logic    rst;
    logic    wr;
    regnum_t wn;
    word_t   din;
    regnum_t rn;
    word_t   exp;
    string   name;
  } vec_t;

  typedef struct {
    word_t exp;
    string name;
  } sb_t;

  logic clk;
  logic reset;
  int   total;
  int   bad;
  sb_t  sb_q [$];
  vec_t vecs [8];

  p3_reg_file_if #(.DATA_W(16), .ADDR_W(3)) bus ();

  p3_reg_file dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_pop();
    sb_t e;
    if (sb_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard_empty actual=none required=entry");
      return;
    end
    e = sb_q.pop_front();
    total++;
    if (bus.data_out !== e.exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", e.name, bus.data_out, e.exp);
    end else begin
      $display("ok   %s data_out=%h", e.name, bus.data_out);
    end
  endtask

  // One clock edge with the given inputs; data_out compared just after the edge.
  task automatic step(input logic rst, input logic wr, input regnum_t wn,
                      input word_t din, input regnum_t rn, input word_t exp,
                      input string name);
    @(negedge clk);
    reset        = rst;
    bus.write    = wr;
    bus.writenum = wn;
    bus.data_in  = din;
    bus.readnum  = rn;
    sb_q.push_back('{exp: exp, name: name});
    @(posedge clk);
    #1;
    check_pop();
  endtask

  // Change readnum only and compare without waiting for an edge.
  task automatic peek(input regnum_t rn, input word_t exp, input string name);
    bus.readnum = rn;
    sb_q.push_back('{exp: exp, name: name});
    #1;
    check_pop();
  endtask

  initial begin
    total        = 0;
    bad          = 0;
    reset        = 1'b0;
    bus.write    = 1'b0;
    bus.writenum = '0;
    bus.data_in  = '0;
    bus.readnum  = '0;

    vecs[0] = '{1'b1, 1'b0, 3'd0, 16'h0000, 3'd0, 16'h0000, "reset_r0"};
    vecs[1] = '{1'b0, 1'b0, 3'd0, 16'hA5A5, 3'd0, 16'h0000, "no_write_r0"};
    vecs[2] = '{1'b1, 1'b0, 3'd0, 16'h0000, 3'd1, 16'h0000, "reset_again"};
    vecs[3] = '{1'b0, 1'b1, 3'd1, 16'h5A5A, 3'd1, 16'h5A5A, "write_r1"};
    vecs[4] = '{1'b0, 1'b0, 3'd1, 16'hFFFF, 3'd1, 16'h5A5A, "hold_r1_a"};
    vecs[5] = '{1'b0, 1'b0, 3'd7, 16'hFFFF, 3'd1, 16'h5A5A, "hold_r1_b"};
    vecs[6] = '{1'b1, 1'b0, 3'd0, 16'h0000, 3'd1, 16'h0000, "reset_clears_r1"};
    vecs[7] = '{1'b0, 1'b1, 3'd2, 16'h1234, 3'd2, 16'h1234, "write_r2"};

    // Reset first, then every index must read zero.
    step(1'b1, 1'b0, 3'd0, 16'h0000, 3'd0, 16'h0000, "init_reset");
    step(1'b0, 1'b0, 3'd0, 16'h0000, 3'd0, 16'h0000, "idle");
    for (int i = 0; i < 8; i++) begin
      peek(regnum_t'(i), 16'h0000, $sformatf("reset_sweep_r%0d", i));
    end

    for (int v = 0; v < 8; v++) begin
      step(vecs[v].rst, vecs[v].wr, vecs[v].wn, vecs[v].din,
           vecs[v].rn, vecs[v].exp, vecs[v].name);
    end

    // Combinational read: select changes without a clock edge.
    peek(3'd3, 16'h0000, "comb_read_r3");
    peek(3'd2, 16'h1234, "comb_read_r2");

    // Distinct pattern in every register, then sweep for aliasing.
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b1, regnum_t'(i), word_t'(16'h1111 * i), regnum_t'(i),
           word_t'(16'h1111 * i), $sformatf("fill_r%0d", i));
    end
    step(1'b0, 1'b0, 3'd0, 16'h0000, 3'd7, 16'h7777, "fill_idle");
    for (int i = 7; i >= 0; i--) begin
      peek(regnum_t'(i), word_t'(16'h1111 * i), $sformatf("fill_sweep_r%0d", i));
    end

    // Reset beats a simultaneous write; the write lands on the next clean edge.
    step(1'b1, 1'b1, 3'd4, 16'hBEEF, 3'd4, 16'h0000, "reset_beats_write_r4");
    peek(3'd6, 16'h0000, "reset_cleared_r6");
    @(negedge clk);
    reset        = 1'b0;
    bus.write    = 1'b1;
    bus.writenum = 3'd4;
    bus.data_in  = 16'hBEEF;
    peek(3'd4, 16'h0000, "r4_before_edge");
    @(posedge clk);
    #1;
    peek(3'd4, 16'hBEEF, "r4_after_edge");

    // Read-during-write to the same index: old value until the edge.
    @(negedge clk);
    bus.data_in = 16'h1357;
    peek(3'd4, 16'hBEEF, "rdw_old_value");
    @(posedge clk);
    #1;
    peek(3'd4, 16'h1357, "rdw_new_value");

    // Consecutive writes to different indices do not disturb each other.
    step(1'b0, 1'b1, 3'd5, 16'hC0DE, 3'd4, 16'h1357, "seq_write_r5");
    step(1'b0, 1'b0, 3'd5, 16'hDEAD, 3'd5, 16'hC0DE, "seq_idle_r5");
    peek(3'd0, 16'h0000, "seq_r0_untouched");

    if (sb_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard_leftover actual=%0d required=0", sb_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/p3_reg_file.md
# p3_reg_file

Eight-entry, 16-bit general-purpose register file for the Simple RISC Machine datapath. It has one synchronous write port and one combinational read port. It sits between the datapath writeback mux (`data_in`) and the operand path (`data_out` feeds the A/B operand registers). The controller drives `writenum`, `readnum` and `write` each cycle.

## Interface
Clocking: one clock; reset is synchronous and active-high (`clk`, `reset`).

Parameters:
- `DATA_W`, default 16: register width in bits.
- `NREGS`, default 8: number of registers; the address width is log2(NREGS) = 3.

Ports:
- `clk`  input  1: rising-edge clock for all state.
- `reset`  input  1: synchronous, active-high clear of all registers.
- `data_in`  input  16: write data.
- `writenum`  input  3: index of the register to write (R0..R7).
- `write`  input  1: write enable.
- `readnum`  input  3: index of the register to read.
- `data_out`  output  16: contents of R[readnum].

## Operation
- Storage is R0..R7, each 16 bits. There is no hardwired-zero register.
- Write: at a rising edge of `clk` with `write`=1 and `reset`=0, R[writenum] <= `data_in`. All other registers hold their values.
- With `write`=0, no register changes, whatever `writenum` and `data_in` are.
- Write decode is a one-hot 3:8 decode of `writenum`, ANDed with `write`. That gives one load enable per register.
- Read: `data_out` = R[readnum], a purely combinational 8:1 mux. It follows `readnum` changes within the same cycle. There is no read enable.
- Reset: at a rising edge with `reset`=1, all eight registers go to 16'h0000.
- Reset has priority over a simultaneous write. The write is dropped.
- Reset asserted in the middle of a sequence clears everything on that edge. Writes resume on the first edge with `reset`=0.
- Every `readnum` value is legal, so there is no out-of-range case. `data_out` is never X after the first reset.

## Timing
- Write latency is 1 edge. The new value is visible on `data_out` just after the capturing edge, when `readnum`=`writenum`.
- Read latency is 0 cycles, combinational from `readnum` and the register state.
- Read-during-write to the same index has no bypass. Before the edge `data_out` shows the old value; after the edge it shows the new value.
- The reset value of `data_out` is 16'h0000 for every `readnum`, from the first edge with `reset`=1.
- Before the first reset, register contents are undefined. The bench must reset first.
- Writes to different indices on consecutive edges are independent, with no hazard.

## Structure
- Shared package `p3_pkg`:
  - `localparam DATA_W = 16`, `REG_ADDR_W = 3`.
  - `typedef logic [15:0] word_t`.
  - `typedef logic [2:0] regnum_t`.
- Decoder: a one-hot `n`→`2^n` decoder. It is instantiated once for the write path. The read path may reuse it to drive a one-hot select mux.
- Sub-module `p3_reg_load_en`: a parameterised DATA_W-bit register with synchronous reset and load enable. It is instantiated eight times.
- Top level: decoder, eight `p3_reg_load_en` instances, and the 8:1 read mux.

## Test plan
1. Reset with `write`=0 and all inputs 0. Sweep `readnum` 0..7 → `data_out`=16'h0000 for every index.
2. `data_in`=16'hA5A5, `writenum`=0, `write`=0 for one edge, then `readnum`=0 → `data_out` stays 16'h0000 (no write).
3. Reset, then `data_in`=16'h5A5A, `writenum`=1, `write`=1 for one edge, then `write`=0 and `readnum`=1 → `data_out`=16'h5A5A. The value is held on later edges while `write`=0.
4. Reset, then write 16'h1234 to R2. `readnum`=3 → 16'h0000, then `readnum`=2 → 16'h1234, changing in the same cycle as `readnum` with no clock edge needed.
5. Write 16'h1111·i to Ri for i=0..7 on consecutive edges. Sweep `readnum` → each index returns its own value, with no aliasing.
6. Hold `write`=1, `writenum`=4, `data_in`=16'hBEEF, and assert `reset` on the same edge → R4 = 16'h0000 (reset wins). Next edge with `reset`=0 → R4 = 16'hBEEF. Reading R4 with `readnum`=4 before that edge shows 0, and after it shows 16'hBEEF.
